// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if
// Groups the conversion handshake (start/channel -> sample/valid/busy) and
// the SPI pins of the ADC into one bundle.
//   slave  : the reader itself (takes requests and miso, drives SPI pins and results)
//   master : the surroundings (request logic plus the ADC device)
interface adc_spi_reader_if #(
    parameter int DATA_BITS = 10
);
    logic                 start;
    logic                 channel;
    logic                 miso;
    logic                 sclk;
    logic                 csN;
    logic                 mosi;
    logic [DATA_BITS-1:0] sample;
    logic                 valid;
    logic                 busy;

    modport master (
        output start, channel, miso,
        input  sclk, csN, mosi, sample, valid, busy
    );

    modport slave (
        input  start, channel, miso,
        output sclk, csN, mosi, sample, valid, busy
    );
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader
// SPI master (mode 0) running one conversion on an MCP3002-style 2-channel
// serial ADC. Every SCLK phase lasts one tick, so SCLK runs at tick rate / 2.
// Ports:
//   clockIn : system clock, rising edge
//   reset   : asynchronous, active-high
//   tick    : one-cycle bit-rate enable from the clock divider
//   bus     : start/channel request, miso in; sclk/csN/mosi, sample/valid/busy out
// Parameters:
//   DATA_BITS     : ADC result width (>= 2)
//   CS_HIGH_TICKS : minimum ticks csN stays high between frames (>= 1)
//
// state    | meaning
// IDLE     | csN high; waiting for an accepted request and a tick to open the frame
// SHIFT    | csN low; sclk toggles each tick, command out on mosi, data in on miso
// COOLDOWN | csN high; counting CS_HIGH_TICKS ticks before busy drops
module adc_spi_reader #(
    parameter int DATA_BITS     = 10,
    parameter int CS_HIGH_TICKS = 2
) (
    input  logic            clockIn,
    input  logic            reset,
    input  logic            tick,
    adc_spi_reader_if.slave bus
);
    // start, single-ended, channel, MSB-first, null bit, then data
    localparam int N_BITS = 4 + 1 + DATA_BITS;
    localparam int BIT_W  = $clog2(N_BITS);
    localparam int CD_W   = (CS_HIGH_TICKS > 1) ? $clog2(CS_HIGH_TICKS) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(N_BITS - 1);
    localparam logic [BIT_W-1:0] FIRST_DATA = BIT_W'(5);
    localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(CS_HIGH_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COOLDOWN
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 pending_q, pending_d;
    logic                 chan_q, chan_d;
    logic                 sclk_q, sclk_d;
    logic                 csn_q, csn_d;
    logic                 mosi_q, mosi_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] sample_q, sample_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 accept;

    // mosi value for frame bit idx; everything past the command is 0
    function automatic logic cmd_bit(input logic [BIT_W-1:0] idx, input logic ch);
        if (idx == BIT_W'(2)) begin
            return ch;
        end else if (idx < BIT_W'(4)) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

    // busy is only low in IDLE, so this is also the IDLE acceptance condition
    assign accept = bus.start && !busy_q;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        pending_d = pending_q;
        chan_d    = chan_q;
        sclk_d    = sclk_q;
        csn_d     = csn_q;
        mosi_d    = mosi_q;
        valid_d   = 1'b0;
        shreg_d   = shreg_q;
        sample_d  = sample_q;
        bit_d     = bit_q;
        cd_d      = cd_q;

        if (accept) begin
            chan_d    = bus.channel;
            busy_d    = 1'b1;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // a request arriving on a tick edge opens the frame on that same tick
                if (tick && (accept || pending_q)) begin
                    csn_d     = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = 1'b1;
                    pending_d = 1'b0;
                    bit_d     = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // command and null bit clock out garbage on miso
                        if (bit_q >= FIRST_DATA) begin
                            shreg_d = {shreg_q[DATA_BITS-2:0], bus.miso};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            csn_d    = 1'b1;
                            mosi_d   = 1'b0;
                            sample_d = shreg_q;
                            valid_d  = 1'b1;
                            cd_d     = CD_LOAD;
                            state_d  = COOLDOWN;
                        end else begin
                            bit_d  = bit_q + BIT_W'(1);
                            mosi_d = cmd_bit(bit_q + BIT_W'(1), chan_q);
                        end
                    end
                end
            end

            COOLDOWN: begin
                if (tick) begin
                    if (cd_q == '0) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            chan_q    <= 1'b0;
            sclk_q    <= 1'b0;
            csn_q     <= 1'b1;
            mosi_q    <= 1'b0;
            valid_q   <= 1'b0;
            shreg_q   <= '0;
            sample_q  <= '0;
            bit_q     <= '0;
            cd_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            chan_q    <= chan_d;
            sclk_q    <= sclk_d;
            csn_q     <= csn_d;
            mosi_q    <= mosi_d;
            valid_q   <= valid_d;
            shreg_q   <= shreg_d;
            sample_q  <= sample_d;
            bit_q     <= bit_d;
            cd_q      <= cd_d;
        end
    end

    assign bus.sclk   = sclk_q;
    assign bus.csN    = csn_q;
    assign bus.mosi   = mosi_q;
    assign bus.sample = sample_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_adc_spi_reader.sv
// Testbench for adc_spi_reader: a behavioural MCP3002-style ADC serves queued
// sample values, a scoreboard pairs every valid with the value requested.
module tb_adc_spi_reader;
    localparam int DB  = 10;
    localparam int CSH = 2;
    localparam int N   = 4 + 1 + DB;

    logic clockIn = 1'b0;
    logic reset   = 1'b0;
    logic tick    = 1'b0;
    int   R       = 1;
    int   div_cnt = 0;
    int   cyc     = 0;
    int   checks  = 0;
    int   passes  = 0;

    adc_spi_reader_if #(.DATA_BITS(DB)) bus ();

    adc_spi_reader #(.DATA_BITS(DB), .CS_HIGH_TICKS(CSH)) dut (
        .clockIn(clockIn),
        .reset  (reset),
        .tick   (tick),
        .bus    (bus)
    );

    always #5 clockIn = ~clockIn;
    always @(posedge clockIn) cyc++;

    // clock divider: one tick every R cycles
    always @(negedge clockIn) begin
        if (div_cnt >= R - 1) div_cnt = 0;
        else div_cnt++;
        tick = (div_cnt == 0);
    end

    logic [DB-1:0] adc_q[$];
    logic [DB-1:0] samp_q[$];
    logic          ch_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // ---------------- ADC model ----------------
    logic          adc_miso = 1'b0;
    logic          prev_sclk = 1'b0;
    logic          prev_csn = 1'b1;
    logic          have_rise = 1'b0;
    logic [DB-1:0] cur_val = '0;
    logic [3:0]    cmd = '0;
    logic          exp_ch;
    int            rcount = 0;
    int            tail_ones = 0;
    int            frames = 0;
    int            csn_fall_cyc = 0;
    int            csn_rise_cyc = 0;
    int            gap;
    logic          held_mode = 1'b0;
    int            held_start_cyc = 0;

    assign bus.miso = adc_miso;

    always @(negedge clockIn) begin
        if (reset) begin
            prev_sclk = 1'b0;
            prev_csn  = 1'b1;
            rcount    = 0;
            have_rise = 1'b0;
            adc_miso  = 1'b0;
        end else begin
            if (prev_csn && !bus.csN) begin
                rcount    = 0;
                tail_ones = 0;
                cmd       = '0;
                cur_val   = '0;
                if (adc_q.size() > 0) cur_val = adc_q.pop_front();
                adc_miso  = 1'($urandom_range(0, 1));
                frames++;
                if (have_rise) begin
                    gap = cyc - csn_rise_cyc;
                    if (held_mode && csn_rise_cyc > held_start_cyc) begin
                        check("csn_gap_held", gap, (CSH + 1) * R);
                    end else begin
                        checks++;
                        if (gap >= (CSH + 1) * R) passes++;
                        else $display("FAIL csn_gap_min: high %0d cycles, need >= %0d", gap, (CSH + 1) * R);
                    end
                end
                csn_fall_cyc = cyc;
            end
            if (!bus.csN && !prev_sclk && bus.sclk) begin
                if (rcount < 4) cmd[3 - rcount] = bus.mosi;
                else if (bus.mosi) tail_ones++;
                rcount++;
            end
            if (!bus.csN && prev_sclk && !bus.sclk) begin
                // next rising edge is index rcount; data bits go out MSB first from index 5
                if (rcount >= 5 && rcount < N) adc_miso = cur_val[DB - 1 - (rcount - 5)];
                else adc_miso = 1'($urandom_range(0, 1));
            end
            if (!prev_csn && bus.csN) begin
                csn_rise_cyc = cyc;
                have_rise    = 1'b1;
                check("sclk_rises_per_frame", rcount, N);
                check("mosi_zero_after_cmd", tail_ones, 0);
                if (ch_q.size() > 0) begin
                    exp_ch = ch_q.pop_front();
                    check("command_bits", 32'(cmd), 32'({1'b1, 1'b1, exp_ch, 1'b1}));
                end else begin
                    checks++;
                    $display("FAIL unexpected_frame: command %0h with no request outstanding", cmd);
                end
            end
            prev_sclk = bus.sclk;
            prev_csn  = bus.csN;
        end
    end

    // ---------------- scoreboard monitor ----------------
    int   valid_count = 0;
    logic prev_valid = 1'b0;

    always @(negedge clockIn) begin
        if (!reset && bus.valid) begin
            valid_count++;
            check("valid_width", 32'(prev_valid), 0);
            if (samp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: sample %0h with no request outstanding", bus.sample);
            end else begin
                check("sample", 32'(bus.sample), 32'(samp_q.pop_front()));
            end
            check("valid_latency", cyc - csn_fall_cyc, 2 * N * R);
        end
        prev_valid = bus.valid;
    end

    // ---------------- stimulus ----------------
    int busy_drops = 0;

    task automatic step();
        @(negedge clockIn);
        #1;
        bus.channel = 1'($urandom);
        if (!bus.busy) busy_drops++;
    endtask

    task automatic set_ratio(input int r);
        @(negedge clockIn);
        #1;
        R = r;
        repeat (2 * r + 2) @(negedge clockIn);
        #1;
    endtask

    task automatic do_frame(input logic ch, input logic [DB-1:0] val);
        adc_q.push_back(val);
        samp_q.push_back(val);
        ch_q.push_back(ch);
        @(negedge clockIn);
        #1;
        bus.start   = 1'b1;
        bus.channel = ch;
        @(negedge clockIn);
        #1;
        bus.start   = 1'b0;
        bus.channel = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            step();
            n++;
        end
        if (bus.busy) begin
            checks++;
            $display("FAIL wait_idle: busy still high after %0d cycles", budget);
        end
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n;
        n = 0;
        while (rcount < target && n < budget) begin
            step();
            n++;
        end
        if (rcount < target) begin
            checks++;
            $display("FAIL wait_rises: %0d rising edges, wanted %0d", rcount, target);
        end
    endtask

    initial begin
        int            v0, f0, n;
        logic          ch;
        logic [DB-1:0] val;
        logic [DB-1:0] last_val;

        bus.start   = 1'b0;
        bus.channel = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("reset_csN", 32'(bus.csN), 1);
        check("reset_sclk", 32'(bus.sclk), 0);
        check("reset_mosi", 32'(bus.mosi), 0);
        check("reset_valid", 32'(bus.valid), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_sample", 32'(bus.sample), 0);
        repeat (3) @(negedge clockIn);
        #2 reset = 1'b0;

        // tick tied high, channel 0
        set_ratio(1);
        do_frame(1'b0, 10'h2A5);
        check("csN_low_on_accept_tick", 32'(bus.csN), 0);
        check("first_mosi_bit", 32'(bus.mosi), 1);
        check("sclk_low_at_cs_fall", 32'(bus.sclk), 0);
        wait_idle(400);
        last_val = 10'h2A5;

        // channel 1, tick every 4 cycles, back-to-back
        set_ratio(4);
        do_frame(1'b1, 10'h3FF);
        wait_idle(1600);
        do_frame(1'b1, 10'h001);
        wait_idle(1600);
        last_val = 10'h001;

        // start pulses during an active frame are ignored
        set_ratio(1);
        v0 = valid_count;
        f0 = frames;
        val = DB'($urandom);
        do_frame(1'b0, val);
        busy_drops = 0;
        wait_rises(3, 200);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_rises(10, 200);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (valid_count == v0 && n < 200) begin
            step();
            n++;
        end
        check("busy_held_through_frame", busy_drops, 0);
        wait_idle(400);
        repeat (40) step();
        check("ignored_start_frames", frames - f0, 1);
        check("ignored_start_valids", valid_count - v0, 1);
        last_val = val;

        // asynchronous reset in mid-frame
        set_ratio(2);
        do_frame(1'b1, DB'($urandom));
        wait_rises(7, 400);
        #2 reset = 1'b1;
        #1;
        check("abort_csN", 32'(bus.csN), 1);
        check("abort_sclk", 32'(bus.sclk), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_valid", 32'(bus.valid), 0);
        check("abort_sample", 32'(bus.sample), 0);
        adc_q.delete();
        samp_q.delete();
        ch_q.delete();
        step();
        step();
        reset = 1'b0;
        v0 = valid_count;
        repeat (60) step();
        check("no_valid_after_abort", valid_count - v0, 0);
        check("sample_after_abort", 32'(bus.sample), 0);
        val = DB'($urandom);
        do_frame(1'b0, val);
        wait_idle(800);
        last_val = val;

        // start held high: frames repeat with minimal gap
        for (int r = 1; r <= 2; r++) begin
            set_ratio(r);
            f0 = frames;
            v0 = valid_count;
            ch = 1'($urandom);
            for (int i = 0; i < 3; i++) begin
                val = DB'($urandom);
                adc_q.push_back(val);
                samp_q.push_back(val);
                ch_q.push_back(ch);
                last_val = val;
            end
            held_start_cyc = cyc;
            held_mode      = 1'b1;
            bus.channel    = ch;
            bus.start      = 1'b1;
            n = 0;
            while (frames < f0 + 3 && n < 400 * r) begin
                @(negedge clockIn);
                #1;
                n++;
            end
            bus.start = 1'b0;
            wait_idle(400 * r);
            held_mode = 1'b0;
            check("held_frames", frames - f0, 3);
            check("held_valids", valid_count - v0, 3);
        end

        // random ratios, channels and values; channel toggles every cycle while busy
        for (int i = 0; i < 6; i++) begin
            set_ratio(int'($urandom_range(1, 5)));
            repeat ($urandom_range(0, 7)) step();
            val = DB'($urandom);
            do_frame(1'($urandom), val);
            wait_idle(400 * R);
            last_val = val;
        end

        repeat (30) step();
        check("scoreboard_drained", samp_q.size(), 0);
        check("sample_hold", 32'(bus.sample), 32'(last_val));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

SPI master that runs one conversion on a 2-channel, 10-bit serial ADC (MCP3002-style command frame) and returns the sample. It sits directly downstream of the clock divider in the ADC demo and uses the divider's one-cycle pulse as its bit-rate enable. Each serial clock phase lasts one tick, so SCLK frequency is tick rate / 2. Results go to the display/consumer logic as a parallel word with a one-cycle valid strobe.

## Interface
Parameters:
- DATA_BITS, 10: ADC result width; width of `sample`.
- CS_HIGH_TICKS, 2: minimum ticks `csN` stays high between frames.

Ports:
- clockIn  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-clockIn-cycle enable from the clock divider; may be tied high.
- start  input  1  conversion request; sampled every clockIn cycle.
- channel  input  1  ADC channel; latched when start is accepted.
- miso  input  1  ADC serial data out.
- sclk  output  1  SPI clock, idle low (mode 0).
- csN  output  1  ADC chip select, active low.
- mosi  output  1  ADC serial data in.
- sample  output  DATA_BITS  last completed result, MSB-first assembled.
- valid  output  1  one-clockIn-cycle pulse when `sample` updates.
- busy  output  1  high from start acceptance until cooldown ends.

## Operation
- Frame: N = 4 + 1 + DATA_BITS bits (15 by default). Command bits on mosi, in order: 1 (start), 1 (single-ended), channel, 1 (MSB first); then the null bit, then data bits. After the command, mosi drives 0.
- States: IDLE, SHIFT, COOLDOWN.
- IDLE: `start` with `busy`=0 is accepted on any clockIn edge: latch `channel`, set `busy`, set a pending flag. At the first edge where tick=1 and (start accepted at this edge or pending): `csN`<=0, `sclk`<=0, `mosi`<=command bit 0, clear pending, go to SHIFT. This edge is T0.
- SHIFT: every tick toggles `sclk`. Rising edge k (k=0..N-1) at tick T(2k+1). Falling edge k at T(2k+2).
- On the tick of rising edge k, if k ≥ 5, shift `miso` into the data shift register (LSB in, MSB-first result). Bits k=0..4 are not captured.
- On the tick of falling edge k with k < N-1, `mosi` takes bit k+1.
- At falling edge N-1 (T(2N), T30 by default): `csN`<=1, `mosi`<=0, `sample`<=shift register, `valid`<=1 for exactly one clockIn cycle. Then go to COOLDOWN.
- COOLDOWN: count CS_HIGH_TICKS ticks. `busy` falls at the last of them and the state returns to IDLE.
- `start` while busy is ignored, not queued. `channel` changes during a frame have no effect.
- `sample` holds its value between conversions and is never cleared except by reset.
- Reset (async, any state): `csN`=1, `sclk`=0, `mosi`=0, `valid`=0, `busy`=0, `sample`=0, pending cleared, state IDLE. An aborted frame produces no valid.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `sclk`, `mosi`, `csN` change only on tick edges. The ADC samples mosi on sclk rising. The ADC drives miso after sclk falling, which gives the block a full tick of setup before capture.
- `csN` falls with sclk low, one tick before the first rising edge. It rises one tick after the last rising edge.
- Latency with tick tied high: start at edge E0 → csN low after E0 → valid high in the cycle after E30 → busy low after E32. The next start is accepted at E33 at the earliest.
- With a divider ratio R (tick every R clockIn cycles), every phase lasts R cycles. Latency = (2N + 1 + CS_HIGH_TICKS) ticks plus up to R-1 cycles of wait for the first tick.
- start arriving on the same edge as a tick: the frame starts on that tick (no extra tick of wait).

## Test plan
- tick high, channel=0, ADC model returns 10'h2A5 → mosi bits 1,1,0,1; exactly 15 sclk rising edges with csN low; sample=10'h2A5; valid high for 1 cycle, 30 cycles after csN falls.
- channel=1, tick every 4 cycles, ADC returns 10'h3FF then 10'h001 in back-to-back requests → mosi third bit=1; samples 3FF then 001; csN high for ≥ 2 ticks (8 cycles) between frames.
- start pulsed at rising edges 3 and 10 of an active frame → no second frame, a single valid, busy stays continuously high.
- Assert reset asynchronously between ticks at rising edge 7 → csN=1, sclk=0, busy=0 immediately, before the next clockIn edge; no valid; sample stays 0. A new start then gives a correct frame.
- start held continuously high → frames repeat. Each is separated by exactly CS_HIGH_TICKS+1 ticks of csN high, and valid pulses once per frame.
- channel toggled every cycle during a frame → mosi command bit matches the value latched at acceptance.
